// File: rtl/count_monitor_if.sv
// Sample/status bundle between an upstream 2-bit counter and count_monitor.
// The master drives the sample strobe, value, direction and clear. The slave (count_monitor) returns the status.
interface count_monitor_if;
   logic       en;
   logic [1:0] cnt;
   logic       dir;
   logic       clr;
   logic       locked;
   logic       err;
   logic       fault;
   logic [3:0] wraps;
   logic [3:0] errs;

   modport master (
      output en, cnt, dir, clr,
      input  locked, err, fault, wraps, errs
   );

   modport slave (
      input  en, cnt, dir, clr,
      output locked, err, fault, wraps, errs
   );
endinterface

// File: rtl/count_monitor.sv
// Watches a 2-bit up/down counter for illegal steps and locks, flags or faults on them. It also counts wrap events.
// Define COUNT_MONITOR_WRAP_SAT_EN to make the wrap counter saturate at 15. Otherwise it rolls over modulo 16.
module count_monitor #(
   parameter int unsigned FAULT_THR = 2
) (
   input logic            clk,
   input logic            hr,
   count_monitor_if.slave mon
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_e;

   localparam logic [1:0] THR = FAULT_THR[1:0];

   state_e     state_q;
   logic [1:0] prev_q;
   logic [1:0] run_q;
   logic       locked_q;
   logic       err_q;
   logic       fault_q;
   logic [3:0] wraps_q;
   logic [3:0] errs_q;

   logic       stall;
   logic       fwd;
   logic       legal;
   logic       wrap_evt;
   logic [1:0] run_d;
   logic [3:0] wraps_d;
   logic [3:0] errs_d;

   always_comb begin
      stall    = (mon.cnt == prev_q);
      fwd      = mon.dir ? (mon.cnt == prev_q + 2'd1) : (mon.cnt == prev_q - 2'd1);
      legal    = stall | fwd;
      wrap_evt = fwd & (mon.dir ? (prev_q == 2'd3) : (prev_q == 2'd0));
      run_d    = run_q + 2'd1;
      errs_d   = (errs_q == 4'hF) ? errs_q : errs_q + 4'd1;
`ifdef COUNT_MONITOR_WRAP_SAT_EN
      wraps_d  = (wraps_q == 4'hF) ? wraps_q : wraps_q + 4'd1;
`else
      wraps_d  = wraps_q + 4'd1;
`endif
   end

   // NOTE: all state is updated with non-blocking assignments in a single clocked process, so every branch reads pre-edge values.
   always_ff @(posedge clk) begin
      if (hr) begin
         state_q  <= IDLE;
         prev_q   <= 2'd0;
         run_q    <= 2'd0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         fault_q  <= 1'b0;
         wraps_q  <= 4'd0;
         errs_q   <= 4'd0;
      end else if (mon.clr) begin
         state_q  <= IDLE;
         run_q    <= 2'd0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mon.en) begin
                  prev_q   <= mon.cnt;
                  run_q    <= 2'd0;
                  state_q  <= TRACK;
                  locked_q <= 1'b1;
               end
            end
            TRACK: begin
               if (mon.en) begin
                  prev_q <= mon.cnt;
                  if (legal) begin
                     run_q <= 2'd0;
                     if (wrap_evt) wraps_q <= wraps_d;
                  end else begin
                     err_q  <= 1'b1;
                     errs_q <= errs_d;
                     run_q  <= run_d;
                     // Reaching the threshold faults on this same edge; err still pulses.
                     if (run_d == THR) begin
                        state_q  <= FAULT;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b1;
                     end
                  end
               end
            end
            FAULT: ;
            default: begin
               state_q  <= IDLE;
               locked_q <= 1'b0;
               fault_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mon.locked = locked_q;
   assign mon.err    = err_q;
   assign mon.fault  = fault_q;
   assign mon.wraps  = wraps_q;
   assign mon.errs   = errs_q;

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter FAULT_THR, default 2, number of consecutive illegal steps that forces FAULT; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 hr  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  sample strobe; cnt sampled only on edges where en=1.
REQ-005 cnt  input  2  current value from the upstream 2-bit counter register output.
REQ-006 dir  input  1  expected count direction; 1=up, 0=down.
REQ-007 clr  input  1  synchronous fault clear; returns FSM to IDLE.
REQ-008 locked  output  1  high while FSM is in TRACK.
REQ-009 err  output  1  one-cycle pulse per illegal step detected.
REQ-010 fault  output  1  high while FSM is in FAULT.
REQ-011 wraps  output  4  count of wrap events seen.
REQ-012 errs  output  4  total illegal steps, saturating at 15.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, TRACK, FAULT; all outputs are registered.
REQ-014 IDLE: on en=1, capture cnt into prev, clear the run counter, go to TRACK; en=0 holds.
REQ-015 TRACK: on en=1, cnt==prev is a legal stall; no counter change, run counter cleared.
REQ-016 TRACK: on en=1, cnt==(prev+1) mod 4 with dir=1, or (prev-1) mod 4 with dir=0, is legal; run counter cleared.
REQ-017 TRACK: any other cnt on en=1 is illegal: err=1 next cycle, errs+1 (saturating), run counter+1.
REQ-018 prev SHALL be updated to cnt on every en=1 sample in TRACK, legal or illegal.
REQ-019 When run counter reaches FAULT_THR, FSM SHALL enter FAULT on that same edge; err still pulses.
REQ-020 Wrap event: legal step 3->0 with dir=1 or 0->3 with dir=0; wraps increments on that edge.
REQ-021 FAULT: ignores en/cnt/dir; locked=0, fault=1; exits to IDLE only on clr=1 or hr=1.
REQ-022 clr=1 in any state SHALL force IDLE and clear the run counter; wraps and errs retained.
REQ-023 Latency: every output reflects the sample taken at edge N after edge N (visible in cycle N+1).
REQ-024 dir changes take effect on the next sample; a step legal under the new dir is legal.
REQ-025 Priority: hr > clr > en; en=0 freezes all state except that the err pulse clears.

Reset
REQ-026 On hr=1 at a rising edge: state=IDLE, prev=0, run counter=0, locked=0, err=0, fault=0, wraps=0, errs=0.
REQ-027 hr asserted mid-TRACK or mid-FAULT SHALL take effect on that edge, discarding the concurrent sample.

Configuration
REQ-028 Macro COUNT_MONITOR_WRAP_SAT_EN defined: wraps saturates at 15.
REQ-029 Macro COUNT_MONITOR_WRAP_SAT_EN undefined: wraps rolls modulo 16 (15 -> 0).

Verification
REQ-030 hr=1 one cycle, then en=1 with cnt 0,1,2,3,0 and dir=1 -> locked=1 from the 2nd cycle, wraps=1, err never high, errs=0.
REQ-031 TRACK with prev=1, dir=1, cnt=3 -> err=1 for exactly one cycle, errs=1; next sample cnt=0 is legal, run counter clears.
REQ-032 FAULT_THR=2, dir=1, samples 0,2,0 -> two err pulses, fault=1 after the 3rd edge, locked=0; further samples ignored; clr=1 -> IDLE, errs=2 kept.
REQ-033 dir=0, samples 1,0,3,2 -> wraps=1, no err; en=0 for 5 cycles with cnt changing -> no output change.
REQ-034 hr=1 and clr=1 together during FAULT with wraps=5 -> all outputs reset, wraps=0.
REQ-035 17 up wraps -> wraps=15 with COUNT_MONITOR_WRAP_SAT_EN defined, wraps=1 without it.
